// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: shared types and constants for the two-requester arbiter.
//   arb_state_t : FSM state encoding (idle / A owns channel / B owns channel)
//   SEL_A/SEL_B : mux select encodings; also used to record the last winner
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_A = 2'd1,
    ARB_GRANT_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux_arbiter_mux_w.sv
// mux_w: WIDTH-bit 2:1 multiplexer, o = s ? b : a.
//   a, b : data inputs (WIDTH)
//   s    : select, 0 picks a, 1 picks b
//   o    : selected data (WIDTH)
module mux_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] o
);

  assign o = s ? b : a;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: two-requester round-robin arbiter owning a shared WIDTH-bit
// channel. Grants one requester at a time, drives the mux select and
// registers the selected payload onto data_out (1-cycle latency).
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   req_a/data_a       : requester A request (held for transfer) and payload
//   req_b/data_b       : requester B request and payload
//   gnt_a/gnt_b        : registered grants, never both high
//   sel                : registered mux select, 0 = A, 1 = B
//   data_out/valid_out : registered selected payload and its qualifier
// Optional build macro ARB_HOLD_TIMEOUT_EN: limits one owner to MAX_HOLD
// consecutive grant cycles when the other requester is waiting.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  arb_state_t       state, state_nxt;
  logic             last_winner;
  logic [WIDTH-1:0] mux_o;
  logic             valid_nxt;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int             CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);
  logic [CW-1:0] hold_cnt;
  logic          hold_exp;

  assign hold_exp = (hold_cnt == HOLD_LAST);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        // Tie goes to whoever did not win last time.
        if (req_a && req_b)
          state_nxt = (last_winner == SEL_A) ? ARB_GRANT_B : ARB_GRANT_A;
        else if (req_a)
          state_nxt = ARB_GRANT_A;
        else if (req_b)
          state_nxt = ARB_GRANT_B;
      end
      ARB_GRANT_A: begin
        if (!req_a)
          state_nxt = req_b ? ARB_GRANT_B : ARB_IDLE;
`ifdef ARB_HOLD_TIMEOUT_EN
        else if (req_b && hold_exp)
          state_nxt = ARB_GRANT_B;
`endif
      end
      ARB_GRANT_B: begin
        if (!req_b)
          state_nxt = req_a ? ARB_GRANT_A : ARB_IDLE;
`ifdef ARB_HOLD_TIMEOUT_EN
        else if (req_a && hold_exp)
          state_nxt = ARB_GRANT_A;
`endif
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Uses the registered grant so a word is only valid while its owner still requests.
  assign valid_nxt = (gnt_a && req_a) || (gnt_b && req_b);

  mux_w #(.WIDTH(WIDTH)) u_mux (
    .a (data_a),
    .b (data_b),
    .s (sel),
    .o (mux_o)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      gnt_a       <= 1'b0;
      gnt_b       <= 1'b0;
      sel         <= SEL_A;
      last_winner <= SEL_B;
      data_out    <= '0;
      valid_out   <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_a     <= (state_nxt == ARB_GRANT_A);
      gnt_b     <= (state_nxt == ARB_GRANT_B);
      valid_out <= valid_nxt;
      // sel keeps its last value through IDLE.
      if (state_nxt == ARB_GRANT_A) begin
        sel         <= SEL_A;
        last_winner <= SEL_A;
      end else if (state_nxt == ARB_GRANT_B) begin
        sel         <= SEL_B;
        last_winner <= SEL_B;
      end
      if (valid_nxt)
        data_out <= mux_o;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  // Clears on every grant entry; saturates so a late arrival is served at once.
  always_ff @(posedge clock) begin
    if (reset)
      hold_cnt <= '0;
    else if (state_nxt != state)
      hold_cnt <= '0;
    else if (state != ARB_IDLE && !hold_exp)
      hold_cnt <= hold_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
module tb_mux_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       gnt_a, gnt_b, sel, valid_out;
  logic [7:0] data_out;

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ga = 1'b0, exp_gb = 1'b0, exp_sel = 1'b0;
  logic [7:0] exp_data = '0;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then check against the expected grants.
  // A word is scoreboarded when its owner holds the grant (per the bench's own
  // expected grants) and keeps requesting this cycle.
  task automatic step(input logic rst, input logic ra, input logic [7:0] da,
                      input logic rb, input logic [7:0] db,
                      input logic ega, input logic egb);
    logic ev;
    reset  = rst;
    req_a  = ra;
    data_a = da;
    req_b  = rb;
    data_b = db;
    ev = !rst && ((exp_ga && ra) || (exp_gb && rb));
    if (ev) exp_q.push_back(exp_ga ? da : db);
    @(posedge clock);
    #1;
    if (rst) begin
      exp_q.delete();
      exp_data = '0;
      exp_sel  = 1'b0;
    end else if (ega) exp_sel = 1'b0;
    else if (egb) exp_sel = 1'b1;
    exp_ga = ega;
    exp_gb = egb;
    chk("gnt_a", {7'd0, gnt_a}, {7'd0, ega});
    chk("gnt_b", {7'd0, gnt_b}, {7'd0, egb});
    chk("sel", {7'd0, sel}, {7'd0, exp_sel});
    chk("valid_out", {7'd0, valid_out}, {7'd0, ev});
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 8'd1, 8'd0);
      end else begin
        exp_data = exp_q.pop_front();
      end
    end
    chk("data_out", data_out, exp_data);
  endtask

  initial begin
    // Reset held two cycles with both requesting.
    step(1, 1, 8'h11, 1, 8'h22, 0, 0);
    step(1, 1, 8'h11, 1, 8'h22, 0, 0);

    // Single requester A.
    step(0, 1, 8'h3C, 0, 8'h00, 1, 0);
    step(0, 1, 8'h3C, 0, 8'h00, 1, 0);
    step(0, 1, 8'h3D, 0, 8'h00, 1, 0);
    step(0, 0, 8'hFF, 0, 8'h00, 0, 0);
    step(0, 0, 8'hEE, 0, 8'h00, 0, 0);

    // Tie after reset: A first, then B with no bubble.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 1, 8'hA1, 1, 8'hB1, 1, 0);
    step(0, 1, 8'hA2, 1, 8'hB2, 1, 0);
    step(0, 1, 8'hA3, 1, 8'hB2, 1, 0);
    step(0, 0, 8'hA4, 1, 8'hB3, 0, 1);
    step(0, 1, 8'hA5, 1, 8'hB4, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);

    // Round-robin: both pulse with one-cycle gaps; last winner is B.
    step(0, 1, 8'h10, 1, 8'h20, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 1, 8'h11, 1, 8'h21, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 1, 8'h12, 1, 8'h22, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 1, 8'h13, 1, 8'h23, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);

    // Mid-transfer reset during GRANT_B.
    step(0, 0, 8'h00, 1, 8'hA5, 0, 1);
    step(0, 0, 8'h00, 1, 8'hA5, 0, 1);
    step(1, 0, 8'h00, 1, 8'hA5, 0, 0);
    step(0, 1, 8'h77, 0, 8'h00, 1, 0);
    step(0, 1, 8'h78, 0, 8'h00, 1, 0);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);

    // Hold timeout: A held, B raised at cycle 2.
    step(1, 0, 8'h00, 0, 8'h00, 0, 0);
    step(0, 1, 8'hC0, 0, 8'h00, 1, 0);
    step(0, 1, 8'hC1, 0, 8'h00, 1, 0);
    step(0, 1, 8'hC2, 1, 8'hD0, 1, 0);
    step(0, 1, 8'hC3, 1, 8'hD1, 1, 0);
    step(0, 1, 8'hC4, 1, 8'hD2, !TMO, TMO);
    step(0, 1, 8'hC5, 1, 8'hD3, !TMO, TMO);
    step(0, 0, 8'hC6, 1, 8'hD4, 0, 1);
    step(0, 0, 8'hC7, 1, 8'hD5, 0, 1);
    step(0, 0, 8'h00, 0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
